// File: rtl/reg_file_sb_if.sv
// Bundle of the write-back, read and issue/scoreboard signals of the decode-stage register file.
// The master side belongs to the pipeline and the slave side belongs to the register file.
interface reg_file_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [DATA_W-1:0]     wr_data;
  logic [DATA_W/8-1:0]   wr_be;
  logic [ADDR_W-1:0]     rd_addr_a;
  logic [ADDR_W-1:0]     rd_addr_b;
  logic                  rd_use_a;
  logic                  rd_use_b;
  logic [DATA_W-1:0]     rd_data_a;
  logic [DATA_W-1:0]     rd_data_b;
  logic                  iss_valid;
  logic [ADDR_W-1:0]     iss_addr;
  logic                  busy_a;
  logic                  busy_b;
  logic                  stall;

  modport master (
    output wr_en, wr_addr, wr_data, wr_be,
    output rd_addr_a, rd_addr_b, rd_use_a, rd_use_b,
    output iss_valid, iss_addr,
    input  rd_data_a, rd_data_b, busy_a, busy_b, stall
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_be,
    input  rd_addr_a, rd_addr_b, rd_use_a, rd_use_b,
    input  iss_valid, iss_addr,
    output rd_data_a, rd_data_b, busy_a, busy_b, stall
  );
endinterface

// File: rtl/reg_file_sb.sv
// Decode-stage register file: two combinational read ports, one byte-enabled write port,
// optional hardwired zero register and write bypass, plus a busy-bit scoreboard driving stall.
module reg_file_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic            clk,
  input  logic            reset,
  reg_file_sb_if.slave    bus
);

  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam int BE_W     = DATA_W / 8;

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;

  logic [DATA_W-1:0]   wr_merged;
  logic                wr_ok;
  logic                fwd_a;
  logic                fwd_b;
  logic                iss_ok;

  // Register 0 is read-only when it is hardwired to zero.
  function automatic logic is_writable(input logic [ADDR_W-1:0] addr);
    return !((ZERO_REG != 0) && (addr == '0));
  endfunction

  // The word a write would leave behind: stored bytes with the enabled lanes replaced.
  always_comb begin
    wr_merged = regs[bus.wr_addr];
    for (int i = 0; i < BE_W; i++) begin
      if (bus.wr_be[i]) begin
        wr_merged[8*i +: 8] = bus.wr_data[8*i +: 8];
      end
    end
  end

  assign wr_ok  = bus.wr_en && is_writable(bus.wr_addr);
  assign fwd_a  = (BYPASS != 0) && wr_ok && (bus.wr_addr == bus.rd_addr_a);
  assign fwd_b  = (BYPASS != 0) && wr_ok && (bus.wr_addr == bus.rd_addr_b);
  assign iss_ok = bus.iss_valid && !bus.stall && is_writable(bus.iss_addr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_ok) begin
      regs[bus.wr_addr] <= wr_merged;
    end
  end

  // Issue is applied after writeback so a newer producer on the same register keeps it busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= '0;
    end else begin
      if (bus.wr_en) begin
        busy[bus.wr_addr] <= 1'b0;
      end
      if (iss_ok) begin
        busy[bus.iss_addr] <= 1'b1;
      end
    end
  end

  always_comb begin
    bus.rd_data_a = '0;
    bus.rd_data_b = '0;
    if (!reset) begin
      if (!is_writable(bus.rd_addr_a)) begin
        bus.rd_data_a = '0;
      end else if (fwd_a) begin
        bus.rd_data_a = wr_merged;
      end else begin
        bus.rd_data_a = regs[bus.rd_addr_a];
      end
      if (!is_writable(bus.rd_addr_b)) begin
        bus.rd_data_b = '0;
      end else if (fwd_b) begin
        bus.rd_data_b = wr_merged;
      end else begin
        bus.rd_data_b = regs[bus.rd_addr_b];
      end
    end
  end

  // A forwarded operand is final, so it no longer counts as pending.
  always_comb begin
    bus.busy_a = 1'b0;
    bus.busy_b = 1'b0;
    if (!reset) begin
      bus.busy_a = busy[bus.rd_addr_a] && !fwd_a;
      bus.busy_b = busy[bus.rd_addr_b] && !fwd_b;
    end
  end

  assign bus.stall = (bus.rd_use_a && bus.busy_a) || (bus.rd_use_b && bus.busy_b);

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: a bypassing instance and a non-bypassing instance share
// one stimulus stream so forwarding and plain timing can be compared cycle by cycle.
module tb_reg_file_sb;

  logic clk = 1'b0;
  logic reset;
  int   total_checks = 0;
  int   passed_checks = 0;

  always #5 clk = ~clk;

  reg_file_sb_if #(.DATA_W(32), .ADDR_W(5)) bus ();
  reg_file_sb_if #(.DATA_W(32), .ADDR_W(5)) bus_nb ();

  assign bus_nb.wr_en     = bus.wr_en;
  assign bus_nb.wr_addr   = bus.wr_addr;
  assign bus_nb.wr_data   = bus.wr_data;
  assign bus_nb.wr_be     = bus.wr_be;
  assign bus_nb.rd_addr_a = bus.rd_addr_a;
  assign bus_nb.rd_addr_b = bus.rd_addr_b;
  assign bus_nb.rd_use_a  = bus.rd_use_a;
  assign bus_nb.rd_use_b  = bus.rd_use_b;
  assign bus_nb.iss_valid = bus.iss_valid;
  assign bus_nb.iss_addr  = bus.iss_addr;

  reg_file_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  reg_file_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_nb.slave)
  );

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    total_checks++;
    assert (observed === expected) passed_checks++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
  endtask

  task automatic apply_stimulus(input logic wr_en, input logic [4:0] wr_addr,
                                input logic [31:0] wr_data, input logic [3:0] wr_be,
                                input logic iss_valid, input logic [4:0] iss_addr);
    bus.wr_en     = wr_en;
    bus.wr_addr   = wr_addr;
    bus.wr_data   = wr_data;
    bus.wr_be     = wr_be;
    bus.iss_valid = iss_valid;
    bus.iss_addr  = iss_addr;
  endtask

  task automatic set_reads(input logic [4:0] addr_a, input logic use_a,
                           input logic [4:0] addr_b, input logic use_b);
    bus.rd_addr_a = addr_a;
    bus.rd_use_a  = use_a;
    bus.rd_addr_b = addr_b;
    bus.rd_use_b  = use_b;
  endtask

  // Inputs change just after a falling edge; the following rising edge commits them.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    apply_stimulus(1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0);
    set_reads(5'd5, 1'b0, 5'd7, 1'b0);
    #2;
    check_output("reset_rd_a", bus.rd_data_a, 32'h0);
    check_output("reset_stall", {31'b0, bus.stall}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Reset mid-run: r5 written, r7 issued, then reset without a clock edge.
    apply_stimulus(1'b1, 5'd5, 32'hDEADBEEF, 4'hF, 1'b0, 5'd0);
    next_cycle();
    apply_stimulus(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd7);
    next_cycle();
    apply_stimulus(1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0);
    @(negedge clk);
    set_reads(5'd5, 1'b0, 5'd7, 1'b1);
    #1;
    check_output("pre_reset_r5", bus.rd_data_a, 32'hDEADBEEF);
    check_output("pre_reset_busy7", {31'b0, bus.busy_b}, 32'h1);
    check_output("pre_reset_stall", {31'b0, bus.stall}, 32'h1);
    reset = 1'b1;
    #1;
    check_output("reset_r5", bus.rd_data_a, 32'h0);
    check_output("reset_busy7", {31'b0, bus.busy_b}, 32'h0);
    check_output("reset_stall_mid", {31'b0, bus.stall}, 32'h0);
    reset = 1'b0;
    #1;
    check_output("post_reset_r5", bus.rd_data_a, 32'h0);
    check_output("post_reset_busy7", {31'b0, bus.busy_b}, 32'h0);
    @(negedge clk);
    set_reads(5'd3, 1'b0, 5'd0, 1'b0);

    // Byte-enabled partial write.
    apply_stimulus(1'b1, 5'd3, 32'h11223344, 4'hF, 1'b0, 5'd0);
    next_cycle();
    apply_stimulus(1'b1, 5'd3, 32'hAABBCCDD, 4'b0101, 1'b0, 5'd0);
    next_cycle();
    apply_stimulus(1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0);
    #1;
    check_output("be_merge_r3", bus.rd_data_a, 32'h11BB33DD);
    check_output("be_merge_r3_nb", bus_nb.rd_data_a, 32'h11BB33DD);
    @(negedge clk);

    // Hardwired zero register ignores writes and never goes busy.
    set_reads(5'd0, 1'b0, 5'd0, 1'b1);
    apply_stimulus(1'b1, 5'd0, 32'hFFFFFFFF, 4'hF, 1'b0, 5'd0);
    #1;
    check_output("r0_no_fwd", bus.rd_data_a, 32'h0);
    next_cycle();
    apply_stimulus(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd0);
    #1;
    check_output("r0_read", bus.rd_data_a, 32'h0);
    next_cycle();
    apply_stimulus(1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0);
    #1;
    check_output("r0_busy", {31'b0, bus.busy_b}, 32'h0);
    check_output("r0_stall", {31'b0, bus.stall}, 32'h0);
    @(negedge clk);

    // Bypass versus no bypass on a same-cycle write.
    set_reads(5'd9, 1'b0, 5'd0, 1'b0);
    apply_stimulus(1'b1, 5'd9, 32'h00000005, 4'hF, 1'b0, 5'd0);
    next_cycle();
    @(negedge clk);
    apply_stimulus(1'b1, 5'd9, 32'hCAFE0000, 4'hF, 1'b0, 5'd0);
    #1;
    check_output("bypass_same_cycle", bus.rd_data_a, 32'hCAFE0000);
    check_output("nobypass_same_cycle", bus_nb.rd_data_a, 32'h00000005);
    next_cycle();
    apply_stimulus(1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0);
    #1;
    check_output("bypass_next_cycle", bus.rd_data_a, 32'hCAFE0000);
    check_output("nobypass_next_cycle", bus_nb.rd_data_a, 32'hCAFE0000);
    @(negedge clk);

    // Stall on a pending source, ignored issue while stalled, release by writeback.
    set_reads(5'd6, 1'b0, 5'd4, 1'b0);
    apply_stimulus(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd4);
    next_cycle();
    apply_stimulus(1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0);
    @(negedge clk);
    set_reads(5'd6, 1'b0, 5'd4, 1'b1);
    #1;
    check_output("stall_busy_b", {31'b0, bus.busy_b}, 32'h1);
    check_output("stall_set", {31'b0, bus.stall}, 32'h1);
    apply_stimulus(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd6);
    next_cycle();
    apply_stimulus(1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0);
    #1;
    check_output("stalled_issue_ignored", {31'b0, bus.busy_a}, 32'h0);
    check_output("stalled_issue_ignored_nb", {31'b0, bus_nb.busy_a}, 32'h0);
    check_output("still_stalled", {31'b0, bus.stall}, 32'h1);
    @(negedge clk);
    apply_stimulus(1'b1, 5'd4, 32'h00000044, 4'hF, 1'b0, 5'd0);
    #1;
    check_output("wb_drops_stall", {31'b0, bus.stall}, 32'h0);
    check_output("wb_fwd_data_b", bus.rd_data_b, 32'h00000044);
    check_output("wb_nb_still_stalled", {31'b0, bus_nb.stall}, 32'h1);
    next_cycle();
    apply_stimulus(1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0);
    #1;
    check_output("after_wb_stall", {31'b0, bus.stall}, 32'h0);
    check_output("after_wb_stall_nb", {31'b0, bus_nb.stall}, 32'h0);
    @(negedge clk);

    // Same-cycle set and clear: set wins; clear alone releases.
    set_reads(5'd8, 1'b0, 5'd0, 1'b0);
    apply_stimulus(1'b1, 5'd8, 32'h00000088, 4'hF, 1'b1, 5'd8);
    next_cycle();
    apply_stimulus(1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0);
    #1;
    check_output("set_wins_busy8", {31'b0, bus.busy_a}, 32'h1);
    check_output("set_wins_busy8_nb", {31'b0, bus_nb.busy_a}, 32'h1);
    @(negedge clk);
    apply_stimulus(1'b1, 5'd8, 32'h00000099, 4'h1, 1'b0, 5'd0);
    #1;
    check_output("clear_fwd_busy8", {31'b0, bus.busy_a}, 32'h0);
    check_output("clear_nofwd_busy8_nb", {31'b0, bus_nb.busy_a}, 32'h1);
    next_cycle();
    apply_stimulus(1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0);
    #1;
    check_output("cleared_busy8", {31'b0, bus.busy_a}, 32'h0);
    check_output("cleared_busy8_nb", {31'b0, bus_nb.busy_a}, 32'h0);
    check_output("r8_data", bus.rd_data_a, 32'h00000099);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised multi-port register file for the pipelined datapath: two combinational read ports, one synchronous write port with byte enables.
- Configurable hardwired zero register and write-to-read bypass.
- Integrated busy-bit scoreboard: issue sets a destination busy, writeback clears it.
- Raises `stall` when a used source operand is still pending.
- Replaces the individual 32-bit enabled registers in the decode stage.

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8.
- ADDR_W, 5, register address width; NUM_REGS = 2**ADDR_W.
- ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes and is never marked busy.
- BYPASS, 1, 1 = a same-cycle write is forwarded to the read ports.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high.
- wr_en  input  1  writeback valid.
- wr_addr  input  ADDR_W  writeback destination.
- wr_data  input  DATA_W  writeback data.
- wr_be  input  DATA_W/8  byte-lane enables; bit i covers data[8i+7:8i].
- rd_addr_a  input  ADDR_W  source A address.
- rd_addr_b  input  ADDR_W  source B address.
- rd_use_a  input  1  instruction in decode uses source A.
- rd_use_b  input  1  instruction in decode uses source B.
- rd_data_a  output  DATA_W  source A data.
- rd_data_b  output  DATA_W  source B data.
- iss_valid  input  1  instruction in decode issues this cycle and writes iss_addr.
- iss_addr  input  ADDR_W  destination of the issuing instruction.
- busy_a  output  1  source A pending.
- busy_b  output  1  source B pending.
- stall  output  1  decode must hold.

Behaviour:

Reset
- Reset is asynchronous and active-high, on clock clk.
- On assertion, all registers clear to 0 and all busy bits clear to 0 immediately, without waiting for clk.
- While reset is high, rd_data_a/b read 0 and busy_a, busy_b and stall read 0.
- Reset mid-operation discards all pending writes and scoreboard state.

Write
- On posedge clk with wr_en=1, each byte lane i with wr_be[i]=1 takes wr_data; lanes with wr_be[i]=0 hold their value.
- wr_en=0: all registers hold. Contents never go to X.
- ZERO_REG=1 and wr_addr=0: the write is discarded.

Read
- Read ports are combinational, with zero-cycle latency.
- ZERO_REG=1 and address 0: the port returns 0.
- BYPASS=1, wr_en=1 and rd_addr equal to a writable wr_addr: the port returns the stored word with the enabled bytes replaced by wr_data.
- BYPASS=0: the port returns the stored word; new data is visible from the next cycle.
- Both ports may address the same register; each port resolves independently.

Scoreboard
- One busy bit per register.
- Clear: posedge clk with wr_en=1 clears busy[wr_addr], regardless of wr_be.
- Set: posedge clk with iss_valid=1 and stall=0 sets busy[iss_addr]. iss_valid is ignored while stall=1.
- Set and clear on the same register in the same cycle: set wins, because a newer producer has issued.
- ZERO_REG=1: busy[0] is never set.
- busy_a = busy[rd_addr_a], except it reads 0 when BYPASS=1, wr_en=1, wr_addr=rd_addr_a and the address is writable (the forwarded value is final). busy_b is defined the same way.
- stall = (rd_use_a & busy_a) | (rd_use_b & busy_b).

Test Plan:
1. Assert reset mid-run after writing 0xDEADBEEF to r5 and issuing r7 -> r5 reads 0 with no clock edge; busy_b (addr 7) = 0; stall = 0.
2. Write r3 = 0x11223344 with be=1111, then r3 = 0xAABBCCDD with be=0101 -> r3 reads 0x11BB33DD.
3. Write r0 = 0xFFFFFFFF (ZERO_REG=1), then iss_valid with iss_addr=0 -> r0 reads 0; busy for r0 stays 0.
4. BYPASS=1: hold r9 = 0x5 and write r9 = 0xCAFE0000 be=1111 while rd_addr_a=9 -> rd_data_a = 0xCAFE0000 in the same cycle. BYPASS=0, same stimulus -> 0x5 in that cycle, 0xCAFE0000 the next.
5. Issue r4; next cycle rd_addr_b=4 with rd_use_b=1 -> stall=1, and an iss_valid for r6 is ignored. Writeback r4 (BYPASS=1) -> stall drops in the same cycle.
6. Same cycle: iss_valid r8 and wr_en r8 -> busy[8] = 1 after the edge. Repeat with only wr_en -> busy[8] = 0.
